// File: rtl/rv_defs.sv
// Shared definitions for the decode stage: RV32 base opcodes, the one-hot
// instruction-format encoding, the skid-buffer state encoding and the
// per-entry payload that is registered in the output and skid registers.
// Optional feature macro: DECODE_ILLEGAL_EN adds an illegal-opcode bit to
// each stored entry.
package rv_defs;

    localparam int unsigned INST_W = 32;
    localparam int unsigned FMT_W  = 6;
    localparam int unsigned ST_W   = 2;

    // Base-ISA major opcodes (inst[6:0])
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // One-hot instruction formats
    localparam logic [FMT_W-1:0] FMT_R = 6'b000001;
    localparam logic [FMT_W-1:0] FMT_I = 6'b000010;
    localparam logic [FMT_W-1:0] FMT_S = 6'b000100;
    localparam logic [FMT_W-1:0] FMT_B = 6'b001000;
    localparam logic [FMT_W-1:0] FMT_U = 6'b010000;
    localparam logic [FMT_W-1:0] FMT_J = 6'b100000;

    // Skid-buffer occupancy states
    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

    // Decoded bundle held in each buffer slot (PC is carried separately
    // because its width is a module parameter)
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [FMT_W-1:0]  format;
        logic [INST_W-1:0] immediate;
`ifdef DECODE_ILLEGAL_EN
        logic              illegal;
`endif
    } dec_entry_t;

endpackage

// File: rtl/imm.sv
// Immediate generator: combinational sign-extended immediate for the
// one-hot format of an instruction. R-type (and any non-matching format)
// yields zero.
// Ports:
//   inst   in  [31:7]  instruction word above the opcode field
//   format in  6       one-hot format [0]R [1]I [2]S [3]B [4]U [5]J
//   imm_c  out 32      immediate (combinational)
module imm
    import rv_defs::*;
(
    input  logic [31:7]      inst,
    input  logic [FMT_W-1:0] format,
    output logic [31:0]      imm_c
);

    // Field scatter per format; format is one-hot so at most one arm applies
    always_comb begin
        imm_c = '0;
        if (format == FMT_I) begin
            imm_c = {{20{inst[31]}}, inst[31:20]};
        end else if (format == FMT_S) begin
            imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end else if (format == FMT_B) begin
            imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end else if (format == FMT_U) begin
            imm_c = {inst[31:12], 12'b0};
        end else if (format == FMT_J) begin
            imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage controller between fetch and execute. Instructions are
// decoded on the input side (format + immediate) and held in a two-entry
// skid buffer (output register + skid register) so fetch can transfer one
// instruction per cycle while execute applies back-pressure.
// Optional feature macro: DECODE_ILLEGAL_EN (registers an illegal-opcode
// flag per entry; otherwise o_illegal is tied low).
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid/o_ready          fetch handshake; i_inst, i_pc payload
//   o_valid/i_ready          execute handshake
//   o_inst, o_pc             buffered instruction and its PC
//   o_format                 one-hot format [0]R [1]I [2]S [3]B [4]U [5]J
//   o_immediate              sign-extended immediate
//   o_illegal                unrecognised opcode flag
module decode_ctrl
    import rv_defs::*;
#(
    parameter int unsigned        PC_W         = 32,
    parameter logic [PC_W-1:0]    RESET_PC_TAG = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [INST_W-1:0] i_inst,
    input  logic [PC_W-1:0]   i_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_pc,
    output logic [FMT_W-1:0]  o_format,
    output logic [INST_W-1:0] o_immediate,
    output logic              o_illegal
);

    logic [ST_W-1:0]   state_q;
    logic [ST_W-1:0]   state_d;
    logic              valid_q;
    logic              ready_q;

    dec_entry_t        out_q;
    logic [PC_W-1:0]   out_pc_q;
    dec_entry_t        skid_q;
    logic [PC_W-1:0]   skid_pc_q;

    logic [FMT_W-1:0]  fmt_c;
    logic [INST_W-1:0] imm_val_c;
    dec_entry_t        in_entry_c;

    logic              in_xfer_c;
    logic              out_xfer_c;
    logic              load_out_c;
    logic              out_from_skid_c;
    logic              load_skid_c;

    // Opcode -> one-hot format; anything unrecognised falls back to R
    always_comb begin
        fmt_c = FMT_R;
        case (i_inst[6:0])
            OP_OP:                                        fmt_c = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt_c = FMT_I;
            OP_STORE:                                     fmt_c = FMT_S;
            OP_BRANCH:                                    fmt_c = FMT_B;
            OP_LUI, OP_AUIPC:                             fmt_c = FMT_U;
            OP_JAL:                                       fmt_c = FMT_J;
            default:                                      fmt_c = FMT_R;
        endcase
    end

    imm u_imm (
        .inst   (i_inst[31:7]),
        .format (fmt_c),
        .imm_c  (imm_val_c)
    );

    // Decoded payload of the incoming word
    always_comb begin
        in_entry_c           = '0;
        in_entry_c.inst      = i_inst;
        in_entry_c.format    = fmt_c;
        in_entry_c.immediate = imm_val_c;
`ifdef DECODE_ILLEGAL_EN
        // Only OP_OP legitimately decodes to R, so R with another opcode is illegal
        in_entry_c.illegal   = (fmt_c == FMT_R) && (i_inst[6:0] != OP_OP);
`endif
    end

    assign in_xfer_c  = i_valid && ready_q;
    assign out_xfer_c = valid_q && i_ready;

    // Next-state and buffer-load control
    always_comb begin
        state_d         = state_q;
        load_out_c      = 1'b0;
        out_from_skid_c = 1'b0;
        load_skid_c     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_c) begin
                    load_out_c = 1'b1;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer_c && out_xfer_c) begin
                    load_out_c = 1'b1;
                end else if (in_xfer_c) begin
                    load_skid_c = 1'b1;
                    state_d     = ST_FULL;
                end else if (out_xfer_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer_c) begin
                    load_out_c      = 1'b1;
                    out_from_skid_c = 1'b1;
                    state_d         = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State plus registered handshake flags derived from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            ready_q <= (state_d != ST_FULL);
        end
    end

    // Output register: refilled from the input or drained from the skid slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q        <= '0;
            out_q.format <= FMT_R;
            out_pc_q     <= RESET_PC_TAG;
        end else if (load_out_c) begin
            if (out_from_skid_c) begin
                out_q    <= skid_q;
                out_pc_q <= skid_pc_q;
            end else begin
                out_q    <= in_entry_c;
                out_pc_q <= i_pc;
            end
        end
    end

    // Skid register: catches the input while the output register is stalled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            skid_q    <= '0;
            skid_pc_q <= '0;
        end else if (load_skid_c) begin
            skid_q    <= in_entry_c;
            skid_pc_q <= i_pc;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_inst      = out_q.inst;
    assign o_pc        = out_pc_q;
    assign o_format    = out_q.format;
    assign o_immediate = out_q.immediate;
`ifdef DECODE_ILLEGAL_EN
    assign o_illegal   = out_q.illegal;
`else
    assign o_illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed cases plus randomized
// handshake traffic checked against a queue-based FIFO model with an
// arithmetic reference decoder.
module tb_decode_ctrl;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] RST_PC = 32'h0000_0000;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            out_ready_dut;
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic            out_valid;
    logic            ex_ready;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_format;
    logic [31:0]     out_imm;
    logic            out_illegal;

    decode_ctrl #(.PC_W(PC_W), .RESET_PC_TAG(RST_PC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_valid),
        .o_ready     (out_ready_dut),
        .i_inst      (inst),
        .i_pc        (pc),
        .o_valid     (out_valid),
        .i_ready     (ex_ready),
        .o_inst      (out_inst),
        .o_pc        (out_pc),
        .o_format    (out_format),
        .o_immediate (out_imm),
        .o_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                             7'b0001111, 7'b1110011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA field definitions, using integer arithmetic
    function automatic void ref_decode(input logic [31:0] w, output logic [5:0] f,
                                       output logic [31:0] im, output logic ill);
        int off;
        f   = 6'b000001;
        im  = 32'h0;
        ill = 1'b0;
        case (w[6:0])
            7'b0110011: f = 6'b000001;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                f  = 6'b000010;
                off = int'(w[30:20]) - (w[31] ? 2048 : 0);
                im = 32'(off);
            end
            7'b0100011: begin
                f  = 6'b000100;
                off = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
                im = 32'(off);
            end
            7'b1100011: begin
                f  = 6'b001000;
                off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                      - (w[31] ? 4096 : 0);
                im = 32'(off);
            end
            7'b0110111, 7'b0010111: begin
                f  = 6'b010000;
                im = w & 32'hFFFF_F000;
            end
            7'b1101111: begin
                f  = 6'b100000;
                off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                      - (w[31] ? (1 << 20) : 0);
                im = 32'(off);
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic check_outputs();
        logic [5:0]  f;
        logic [31:0] im;
        logic        il;
        chk("o_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("o_ready", 64'(out_ready_dut), 64'(q.size() < 2));
        if (q.size() > 0) begin
            ref_decode(q[0].inst, f, im, il);
`ifndef DECODE_ILLEGAL_EN
            il = 1'b0;
`endif
            chk("o_inst", 64'(out_inst), 64'(q[0].inst));
            chk("o_pc", 64'(out_pc), 64'(q[0].pc));
            chk("o_format", 64'(out_format), 64'(f));
            chk("o_immediate", 64'(out_imm), 64'(im));
            chk("o_illegal", 64'(out_illegal), 64'(il));
        end
    endtask

    // One clock: drive inputs, advance the FIFO model at the edge, check at negedge
    task automatic cycle(input logic v, input logic [31:0] w, input logic [PC_W-1:0] p,
                         input logic rdy);
        bit   in_x;
        bit   out_x;
        ent_t e;
        in_valid = v;
        inst     = w;
        pc       = p;
        ex_ready = rdy;
        in_x  = v && (q.size() < 2);
        out_x = (q.size() > 0) && rdy;
        e.inst = w;
        e.pc   = p;
        @(posedge clk);
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(e);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset(input logic v);
        rst      = 1'b1;
        in_valid = v;
        inst     = 32'h0000_0013;
        ex_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        int unsigned sel;
        logic [6:0]  op;
        sel = $urandom_range(0, 13);
        if (sel < 11) op = ops[sel];
        else op = 7'($urandom);
        return {25'($urandom), op};
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        inst     = '0;
        pc       = '0;
        ex_ready = 1'b0;
        @(negedge clk);
        apply_reset(1'b0);

        // Reset values
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(out_ready_dut), 64'd1);
        chk("rst_inst", 64'(out_inst), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'(RST_PC));
        chk("rst_format", 64'(out_format), 64'h01);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);

        // addi x1,x0,-1: one-cycle latency
        cycle(1'b1, 32'hFFF0_0093, 32'h100, 1'b1);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_format", 64'(out_format), 64'h02);
        chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);

        // lui then beq back-to-back
        cycle(1'b1, 32'h1234_50B7, 32'h104, 1'b1);
        chk("lui_format", 64'(out_format), 64'h10);
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        cycle(1'b1, 32'hFE00_0EE3, 32'h108, 1'b1);
        chk("beq_format", 64'(out_format), 64'h08);
        chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Back-pressure: two accepted, third stalled, then drain in order
        cycle(1'b1, 32'h0010_0093, 32'h200, 1'b0);
        cycle(1'b1, 32'h0020_0113, 32'h204, 1'b0);
        chk("stall_ready", 64'(out_ready_dut), 64'd0);
        cycle(1'b1, 32'h0030_0193, 32'h208, 1'b0);
        chk("stall_head", 64'(out_inst), 64'h0010_0093);
        cycle(1'b1, 32'h0030_0193, 32'h208, 1'b1);
        chk("release_ready", 64'(out_ready_dut), 64'd1);
        chk("release_head", 64'(out_inst), 64'h0020_0113);
        cycle(1'b1, 32'h0030_0193, 32'h208, 1'b1);
        chk("third_head", 64'(out_inst), 64'h0030_0193);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // All-zero word: unrecognised opcode
        cycle(1'b1, 32'h0000_0000, 32'h300, 1'b1);
`ifdef DECODE_ILLEGAL_EN
        chk("zero_illegal", 64'(out_illegal), 64'd1);
`else
        chk("zero_illegal", 64'(out_illegal), 64'd0);
`endif
        chk("zero_format", 64'(out_format), 64'h01);
        chk("zero_imm", 64'(out_imm), 64'd0);

        // jal with only the sign bit set
        cycle(1'b1, 32'h8000_006F, 32'h304, 1'b1);
        chk("jal_format", 64'(out_format), 64'h20);
        chk("jal_imm", 64'(out_imm), 64'hFFF0_0000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Reset while FULL discards both entries
        cycle(1'b1, 32'h0000_0013, 32'h400, 1'b0);
        cycle(1'b1, 32'h0000_0063, 32'h404, 1'b0);
        chk("full_ready", 64'(out_ready_dut), 64'd0);
        apply_reset(1'b1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(out_ready_dut), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset(1'($urandom));
                check_outputs();
            end else begin
                cycle(1'($urandom_range(0, 9) < 7), rand_inst(), PC_W'($urandom),
                      1'($urandom_range(0, 9) < 6));
            end
        end

        // Drain
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        chk("drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
